fetch_mt_scheduler: RTL and testbench
=====================================

Name: fetch_mt_scheduler

Overview:
Parametrised multithreaded instruction-fetch front end, the successor to the single-path fetch stage. Holds per-thread PCs and fetch state. Round-robin selects an eligible thread and issues one lookup per cycle to the I-TLB/I-cache pair (fixed 1-cycle response). Buffers results in a 2-entry output queue toward IF/ID with valid/ready handshake. Handles I-cache miss parking and wake-up, I-TLB miss reporting, and per-thread redirects with squash.

Parameters:
N_THREADS, 4, hardware thread count (>=2); TID_W = $clog2(N_THREADS)
VADDR_W, 32, virtual PC width
WORD_W, 32, instruction width
RESET_PC, 32'h0000_1000, PC loaded into every thread at reset
PC_STEP, 4, PC increment per fetched instruction

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
ext_stall  in  N_THREADS  per-thread stall from later stages; thread ineligible while set
redirect_en  in  1  redirect strobe
redirect_thread  in  TID_W  thread being redirected
redirect_pc  in  VADDR_W  new PC
cache_req_valid  out  1  lookup issued this cycle
cache_req_pc  out  VADDR_W  virtual PC of lookup
cache_req_thread  out  TID_W  issuing thread
cache_rsp_valid  in  1  response; asserted exactly 1 cycle after cache_req_valid
cache_rsp_hit  in  1  I-cache hit
cache_rsp_tlbmiss  in  1  I-TLB miss (overrides hit)
cache_rsp_data  in  WORD_W  instruction on hit
fill_done  in  1  I-cache refill completed
fill_thread  in  TID_W  thread whose refill completed
out_valid  out  1  IF/ID entry valid
out_ready  in  1  IF/ID accepts
out_pc  out  VADDR_W  PC of entry
out_instr  out  WORD_W  instruction (0 when out_itlb_miss)
out_thread  out  TID_W  thread of entry
out_itlb_miss  out  1  entry carries an I-TLB miss exception
thread_waiting  out  N_THREADS  thread parked (WAIT_FILL or PARKED)

Behaviour:
- Reset (rst=0, async): all PCs=RESET_PC; all threads READY; RR pointer selects thread 0 first; queue empty; all outputs 0.
- Per-thread states: READY, INFLIGHT, WAIT_FILL, PARKED.
- Eligible = READY && !ext_stall[t] && !(redirect_en && redirect_thread==t).
- Issue allowed when queue_count + inflight_count < 2, where inflight_count is 0 or 1 (request from the previous cycle).
- Issue picks the first eligible thread strictly after the last granted thread, wrapping modulo N_THREADS.
- On issue: cache_req_valid=1, pc/thread driven combinationally; thread goes READY->INFLIGHT. No eligible thread -> cache_req_valid=0, pointer unchanged.
- Response, in the cycle after issue, applied to the INFLIGHT thread:
  - tlbmiss: push {pc, 0, thread, itlb=1}; thread -> PARKED; PC unchanged.
  - hit: push {pc, data, thread, 0}; PC += PC_STEP, wrapping modulo 2^VADDR_W; thread -> READY.
  - else (cache miss): no push; thread -> WAIT_FILL; PC unchanged.
- fill_done: WAIT_FILL -> READY for fill_thread. Ignored for any other state or for an out-of-range thread.
- Redirect (redirect_thread < N_THREADS, otherwise ignored):
  - PC <- redirect_pc; state -> READY from any state.
  - A same-cycle response for that thread is discarded; redirect wins.
  - Queue entries of that thread are invalidated the same cycle; the queue is compacted, order preserved.
- Output queue: 2 entries, FIFO, registered outputs. out_* reflect the head.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are allowed when full.
  - Head fields are held stable while out_valid && !out_ready.
- Simultaneous fill_done and redirect for the same thread: redirect result (READY, new PC).
- thread_waiting[t] = state in {WAIT_FILL, PARKED}, combinational from state regs.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_fetched and perf_cmiss, each N_THREADS*32 bits.
  - Per-thread 32-bit wrapping counters.
  - perf_fetched increments on each hit push; perf_cmiss increments on each cache-miss response.
  - Squashed responses are not counted; counters reset to 0.
- Undefined: ports present, tied to 0, no counter logic.

Test Plan:
- Reset, 4 threads, no stalls, always hit, out_ready=1 -> threads fetched 0,1,2,3,0; thread 0 PCs 0x1000 then 0x1004; one instr/cycle sustained after cycle 2.
- ext_stall=4'b0010, always hit -> grant order 0,2,3,0; thread 1 never issued; thread 1 PC stays 0x1000.
- Thread 2 response miss -> thread_waiting=4'b0100, others continue. fill_done thread 2 -> next fetch of thread 2 at the same PC 0x1000.
- out_ready=0 for 5 cycles -> exactly 2 entries queued, cache_req_valid drops to 0, head unchanged. out_ready=1 -> entries drain in order, no loss or duplicate.
- Redirect thread 1 to 0x2000 while thread 1 is INFLIGHT and has one queued entry -> both squashed; next thread 1 output has out_pc=0x2000.
- Response tlbmiss for thread 3 -> out_itlb_miss=1, out_instr=0, thread 3 PARKED until redirect; with the macro defined, perf_fetched[3] is unchanged.

Source files
------------

// File: rtl/fetch_mt_scheduler.sv
// Multithreaded fetch front end: round-robin issue, miss parking, squash.
// Optional per-thread perf counters: define FETCH_PERF_CNT_EN.
module fetch_mt_scheduler #(
    parameter int N_THREADS = 4,
    parameter int VADDR_W = 32,
    parameter int WORD_W = 32,
    parameter logic [VADDR_W-1:0] RESET_PC = 32'h0000_1000,
    parameter int PC_STEP = 4,
    localparam int TID_W = $clog2(N_THREADS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_THREADS-1:0]    ext_stall,
    input  logic                    redirect_en,
    input  logic [TID_W-1:0]        redirect_thread,
    input  logic [VADDR_W-1:0]      redirect_pc,
    output logic                    cache_req_valid,
    output logic [VADDR_W-1:0]      cache_req_pc,
    output logic [TID_W-1:0]        cache_req_thread,
    input  logic                    cache_rsp_valid,
    input  logic                    cache_rsp_hit,
    input  logic                    cache_rsp_tlbmiss,
    input  logic [WORD_W-1:0]       cache_rsp_data,
    input  logic                    fill_done,
    input  logic [TID_W-1:0]        fill_thread,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [VADDR_W-1:0]      out_pc,
    output logic [WORD_W-1:0]       out_instr,
    output logic [TID_W-1:0]        out_thread,
    output logic                    out_itlb_miss,
    output logic [N_THREADS-1:0]    thread_waiting,
    output logic [N_THREADS*32-1:0] perf_fetched,
    output logic [N_THREADS*32-1:0] perf_cmiss
);

    typedef enum logic [1:0] {S_READY, S_INFL, S_WFILL, S_PARK} st_e;

    typedef struct packed {
        logic               v;
        logic [VADDR_W-1:0] pc;
        logic [WORD_W-1:0]  ins;
        logic [TID_W-1:0]   tid;
        logic               itlb;
    } qe_t;

    st_e                r_st [N_THREADS];
    logic [VADDR_W-1:0] r_pc [N_THREADS];
    logic [TID_W-1:0]   r_last;
    logic               r_infl_v;
    logic [TID_W-1:0]   r_infl_tid;
    qe_t                r_q [2];

    logic                 w_rd_ok, w_rsp_ok, w_hit_push, w_tlb_push, w_push;
    logic                 w_pop, w_room, w_sel_v, w_issue;
    logic [TID_W-1:0]     w_sel;
    logic [N_THREADS-1:0] w_elig;
    qe_t                  w_new;
    qe_t                  w_qn [2];

    assign w_rd_ok    = redirect_en && (int'(redirect_thread) < N_THREADS);
    // a redirect of the in-flight thread discards its response
    assign w_rsp_ok   = r_infl_v && cache_rsp_valid
                     && !(w_rd_ok && redirect_thread == r_infl_tid);
    assign w_tlb_push = w_rsp_ok && cache_rsp_tlbmiss;
    assign w_hit_push = w_rsp_ok && !cache_rsp_tlbmiss && cache_rsp_hit;
    assign w_push     = w_tlb_push || w_hit_push;
    assign w_pop      = r_q[0].v && out_ready;
    assign w_room     = (int'(r_q[0].v) + int'(r_q[1].v) - int'(w_pop)
                       + int'(r_infl_v)) < 2;

    always_comb begin
        w_elig = '0;
        for (int t = 0; t < N_THREADS; t++)
            w_elig[t] = (r_st[t] == S_READY) && !ext_stall[t]
                     && !(w_rd_ok && redirect_thread == TID_W'(t));
    end

    always_comb begin
        int idx;
        idx = 0;
        w_sel_v = 1'b0;
        w_sel = '0;
        for (int k = 1; k <= N_THREADS; k++) begin
            idx = (int'(r_last) + k) % N_THREADS;
            if (!w_sel_v && w_elig[idx]) begin
                w_sel_v = 1'b1;
                w_sel = TID_W'(idx);
            end
        end
    end

    assign w_issue          = w_sel_v && w_room && rst;
    assign cache_req_valid  = w_issue;
    assign cache_req_pc     = w_issue ? r_pc[w_sel] : '0;
    assign cache_req_thread = w_issue ? w_sel : '0;

    always_comb begin
        int n;
        logic w_keep0, w_keep1;
        n = 0;
        w_new.v    = w_push;
        w_new.pc   = r_pc[r_infl_tid];
        w_new.ins  = w_hit_push ? cache_rsp_data : '0;
        w_new.tid  = r_infl_tid;
        w_new.itlb = w_tlb_push;
        w_keep0 = r_q[0].v && !w_pop
               && !(w_rd_ok && r_q[0].tid == redirect_thread);
        w_keep1 = r_q[1].v
               && !(w_rd_ok && r_q[1].tid == redirect_thread);
        w_qn[0] = '0;
        w_qn[1] = '0;
        // compact survivors toward the head, then append the new entry
        if (w_keep0) begin
            w_qn[0] = r_q[0];
            n = 1;
        end
        if (w_keep1) begin
            if (n == 0) w_qn[0] = r_q[1];
            else        w_qn[1] = r_q[1];
            n = n + 1;
        end
        if (w_push) begin
            if (n == 0)      w_qn[0] = w_new;
            else if (n == 1) w_qn[1] = w_new;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < N_THREADS; t++) begin
                r_st[t] <= S_READY;
                r_pc[t] <= RESET_PC;
            end
            r_last     <= TID_W'(N_THREADS - 1);
            r_infl_v   <= 1'b0;
            r_infl_tid <= '0;
            r_q[0]     <= '0;
            r_q[1]     <= '0;
        end else begin
            r_infl_v <= w_issue;
            if (w_issue) begin
                r_infl_tid <= w_sel;
                r_last     <= w_sel;
            end
            r_q[0] <= w_qn[0];
            r_q[1] <= w_qn[1];
            for (int t = 0; t < N_THREADS; t++) begin
                if (w_rd_ok && redirect_thread == TID_W'(t)) begin
                    r_st[t] <= S_READY;
                    r_pc[t] <= redirect_pc;
                end else if (w_rsp_ok && r_infl_tid == TID_W'(t)) begin
                    if (cache_rsp_tlbmiss) begin
                        r_st[t] <= S_PARK;
                    end else if (cache_rsp_hit) begin
                        r_st[t] <= S_READY;
                        r_pc[t] <= r_pc[t] + VADDR_W'(PC_STEP);
                    end else begin
                        r_st[t] <= S_WFILL;
                    end
                end else if (w_issue && w_sel == TID_W'(t)) begin
                    r_st[t] <= S_INFL;
                end else if (fill_done && fill_thread == TID_W'(t)
                             && r_st[t] == S_WFILL) begin
                    r_st[t] <= S_READY;
                end
            end
        end
    end

    always_comb begin
        thread_waiting = '0;
        for (int t = 0; t < N_THREADS; t++)
            thread_waiting[t] = (r_st[t] == S_WFILL) || (r_st[t] == S_PARK);
    end

    assign out_valid     = r_q[0].v;
    assign out_pc        = r_q[0].pc;
    assign out_instr     = r_q[0].ins;
    assign out_thread    = r_q[0].tid;
    assign out_itlb_miss = r_q[0].itlb;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_pf [N_THREADS];
    logic [31:0] r_pm [N_THREADS];
    logic        w_cmiss;

    assign w_cmiss = w_rsp_ok && !cache_rsp_tlbmiss && !cache_rsp_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < N_THREADS; t++) begin
                r_pf[t] <= '0;
                r_pm[t] <= '0;
            end
        end else begin
            if (w_hit_push) r_pf[r_infl_tid] <= r_pf[r_infl_tid] + 32'd1;
            if (w_cmiss)    r_pm[r_infl_tid] <= r_pm[r_infl_tid] + 32'd1;
        end
    end

    always_comb begin
        perf_fetched = '0;
        perf_cmiss = '0;
        for (int t = 0; t < N_THREADS; t++) begin
            perf_fetched[t*32 +: 32] = r_pf[t];
            perf_cmiss[t*32 +: 32]   = r_pm[t];
        end
    end
`else
    assign perf_fetched = '0;
    assign perf_cmiss   = '0;
`endif

endmodule

// File: tb/tb_fetch_mt_scheduler.sv
// Directed bench for fetch_mt_scheduler: vector table plus corner sequences.
module tb_fetch_mt_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   ext_stall = '0;
    logic         redirect_en = 1'b0;
    logic [1:0]   redirect_thread = '0;
    logic [31:0]  redirect_pc = '0;
    logic         cache_req_valid;
    logic [31:0]  cache_req_pc;
    logic [1:0]   cache_req_thread;
    logic         cache_rsp_valid = 1'b0;
    logic         cache_rsp_hit = 1'b0;
    logic         cache_rsp_tlbmiss = 1'b0;
    logic [31:0]  cache_rsp_data = '0;
    logic         fill_done = 1'b0;
    logic [1:0]   fill_thread = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_pc;
    logic [31:0]  out_instr;
    logic [1:0]   out_thread;
    logic         out_itlb_miss;
    logic [3:0]   thread_waiting;
    logic [127:0] perf_fetched;
    logic [127:0] perf_cmiss;

    fetch_mt_scheduler dut (
        .clk(clk), .rst(rst), .ext_stall(ext_stall),
        .redirect_en(redirect_en), .redirect_thread(redirect_thread),
        .redirect_pc(redirect_pc),
        .cache_req_valid(cache_req_valid), .cache_req_pc(cache_req_pc),
        .cache_req_thread(cache_req_thread),
        .cache_rsp_valid(cache_rsp_valid), .cache_rsp_hit(cache_rsp_hit),
        .cache_rsp_tlbmiss(cache_rsp_tlbmiss),
        .cache_rsp_data(cache_rsp_data),
        .fill_done(fill_done), .fill_thread(fill_thread),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_thread(out_thread),
        .out_itlb_miss(out_itlb_miss), .thread_waiting(thread_waiting),
        .perf_fetched(perf_fetched), .perf_cmiss(perf_cmiss)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int mode [N];
    logic       rq_v;
    logic [1:0] rq_t;
    logic [31:0] rq_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [1:0]  tid;
        logic        itlb;
    } acc_t;
    acc_t acc [$];

    typedef struct {
        bit rs; logic [3:0] st; bit rdy;
        bit rv; logic [1:0] rt; logic [31:0] rpc;
        bit ov; logic [1:0] ot; logic [31:0] opc;
    } vec_t;
    vec_t tv [$];

    function automatic logic [31:0] f(logic [31:0] pc, logic [1:0] t);
        return pc ^ 32'hC0DE_0000 ^ {30'd0, t};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // instruction memory model: answers the previous cycle's request
    task automatic step();
        @(negedge clk);
        rq_v = cache_req_valid;
        rq_t = cache_req_thread;
        rq_pc = cache_req_pc;
        if (out_valid && out_ready)
            acc.push_back('{pc:out_pc, ins:out_instr, tid:out_thread,
                            itlb:out_itlb_miss});
        @(posedge clk);
        #1;
        cache_rsp_valid = rq_v;
        cache_rsp_hit = rq_v && mode[rq_t] == 0;
        cache_rsp_tlbmiss = rq_v && mode[rq_t] == 2;
        cache_rsp_data = rq_v ? f(rq_pc, rq_t) : '0;
        fill_done = 1'b0;
        redirect_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cache_rsp_valid = 1'b0;
        cache_rsp_hit = 1'b0;
        cache_rsp_tlbmiss = 1'b0;
        cache_rsp_data = '0;
        fill_done = 1'b0;
        redirect_en = 1'b0;
        ext_stall = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) mode[i] = 0;
        #3;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.req_valid", cache_req_valid, 0);
        chk("rst.waiting", thread_waiting, 0);
        chk("rst.out_pc", out_pc, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        acc.delete();
    endtask

    task automatic addv(bit rs, logic [3:0] st, bit rdy, bit rv,
                        logic [1:0] rt, logic [31:0] rpc, bit ov,
                        logic [1:0] ot, logic [31:0] opc);
        vec_t v;
        v.rs = rs; v.st = st; v.rdy = rdy;
        v.rv = rv; v.rt = rt; v.rpc = rpc;
        v.ov = ov; v.ot = ot; v.opc = opc;
        tv.push_back(v);
    endtask

    logic [31:0] exp_cm;
    bit found;

    initial begin
        // round robin, all hit
        addv(1, 4'b0000, 1, 1, 0, 32'h1000, 0, 0, 32'h0);
        addv(0, 4'b0000, 1, 1, 1, 32'h1000, 0, 0, 32'h0);
        addv(0, 4'b0000, 1, 1, 2, 32'h1000, 1, 0, 32'h1000);
        addv(0, 4'b0000, 1, 1, 3, 32'h1000, 1, 1, 32'h1000);
        addv(0, 4'b0000, 1, 1, 0, 32'h1004, 1, 2, 32'h1000);
        addv(0, 4'b0000, 1, 1, 1, 32'h1004, 1, 3, 32'h1000);
        addv(0, 4'b0000, 1, 1, 2, 32'h1004, 1, 0, 32'h1004);
        // thread 1 stalled
        addv(1, 4'b0010, 1, 1, 0, 32'h1000, 0, 0, 32'h0);
        addv(0, 4'b0010, 1, 1, 2, 32'h1000, 0, 0, 32'h0);
        addv(0, 4'b0010, 1, 1, 3, 32'h1000, 1, 0, 32'h1000);
        addv(0, 4'b0010, 1, 1, 0, 32'h1004, 1, 2, 32'h1000);
        addv(0, 4'b0010, 1, 1, 2, 32'h1004, 1, 3, 32'h1000);
        addv(0, 4'b0000, 1, 1, 3, 32'h1004, 1, 0, 32'h1004);
        addv(0, 4'b0000, 1, 1, 0, 32'h1008, 1, 2, 32'h1004);
        addv(0, 4'b0000, 1, 1, 1, 32'h1000, 1, 3, 32'h1004);

        foreach (tv[i]) begin
            if (tv[i].rs) do_reset();
            ext_stall = tv[i].st;
            out_ready = tv[i].rdy;
            #1;
            chk($sformatf("v%0d.req_v", i), cache_req_valid, tv[i].rv);
            if (tv[i].rv) begin
                chk($sformatf("v%0d.req_t", i), cache_req_thread, tv[i].rt);
                chk($sformatf("v%0d.req_pc", i), cache_req_pc, tv[i].rpc);
            end
            chk($sformatf("v%0d.out_v", i), out_valid, tv[i].ov);
            if (tv[i].ov) begin
                chk($sformatf("v%0d.out_t", i), out_thread, tv[i].ot);
                chk($sformatf("v%0d.out_pc", i), out_pc, tv[i].opc);
                chk($sformatf("v%0d.out_ins", i), out_instr,
                    f(tv[i].opc, tv[i].ot));
            end
            step();
        end

        // cache miss on thread 2, then refill
        do_reset();
        mode[2] = 1;
        step(); step(); step(); step();
        #1;
        chk("miss.waiting", thread_waiting, 4'b0100);
        chk("miss.req_t0", cache_req_thread, 0);
        chk("miss.req_pc0", cache_req_pc, 32'h1004);
        mode[2] = 0;
        step(); step();
        #1;
        chk("miss.skip_t2", cache_req_thread, 3);
        fill_done = 1'b1;
        fill_thread = 2'd2;
        step();
        #1;
        chk("miss.wake", thread_waiting, 0);
        found = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            #1;
            if (cache_req_valid && cache_req_thread == 2) begin
                found = 1;
                chk("miss.refetch_pc", cache_req_pc, 32'h1000);
            end else begin
                step();
            end
        end
        if (!found) chk("miss.refetch_timeout", 0, 1);
`ifdef FETCH_PERF_CNT_EN
        exp_cm = 1;
`else
        exp_cm = 0;
`endif
        chk("miss.perf_cmiss2", perf_cmiss[2*32 +: 32], exp_cm);

        // backpressure: queue fills, issue stops, then drains in order
        do_reset();
        out_ready = 1'b0;
        step(); step();
        for (int c = 2; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d.req_v", c), cache_req_valid, 0);
            chk($sformatf("bp%0d.head_t", c), out_thread, 0);
            chk($sformatf("bp%0d.head_pc", c), out_pc, 32'h1000);
            step();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        chk("bp.drain_cnt", acc.size() >= 4, 1);
        if (acc.size() >= 4) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("bp.drain%0d_t", j), acc[j].tid, j);
                chk($sformatf("bp.drain%0d_pc", j), acc[j].pc, 32'h1000);
            end
        end

        // redirect thread 1 with one entry queued and one in flight
        do_reset();
        ext_stall = 4'b1101;
        out_ready = 1'b0;
        #1;
        chk("rd.req0_pc", cache_req_pc, 32'h1000);
        step(); step();
        #1;
        chk("rd.req1_pc", cache_req_pc, 32'h1004);
        step();
        chk("rd.queued", out_valid && out_thread == 1, 1);
        redirect_en = 1'b1;
        redirect_thread = 2'd1;
        redirect_pc = 32'h2000;
        #1;
        chk("rd.no_issue", cache_req_valid, 0);
        step();
        #1;
        chk("rd.squashed", out_valid, 0);
        out_ready = 1'b1;
        #1;
        chk("rd.req_new_pc", cache_req_pc, 32'h2000);
        acc.delete();
        step(); step(); step();
        chk("rd.out_cnt", acc.size() >= 1, 1);
        if (acc.size() >= 1) begin
            chk("rd.out_pc", acc[0].pc, 32'h2000);
            chk("rd.out_ins", acc[0].ins, f(32'h2000, 2'd1));
        end

        // I-TLB miss parks thread 3 until redirect; PC wrap afterwards
        do_reset();
        ext_stall = 4'b0111;
        mode[3] = 2;
        #1;
        chk("tlb.req_t", cache_req_thread, 3);
        step(); step();
        chk("tlb.out_v", out_valid, 1);
        chk("tlb.itlb", out_itlb_miss, 1);
        chk("tlb.instr", out_instr, 0);
        chk("tlb.out_pc", out_pc, 32'h1000);
        chk("tlb.waiting", thread_waiting, 4'b1000);
        fill_done = 1'b1;
        fill_thread = 2'd3;
        step();
        #1;
        chk("tlb.fill_ignored", thread_waiting, 4'b1000);
        chk("tlb.no_req", cache_req_valid, 0);
        chk("tlb.perf_fetched3", perf_fetched[3*32 +: 32], 0);
        step();
        mode[3] = 0;
        redirect_en = 1'b1;
        redirect_thread = 2'd3;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("tlb.rd_no_req", cache_req_valid, 0);
        step();
        #1;
        chk("tlb.unparked", thread_waiting, 0);
        chk("tlb.req_pc", cache_req_pc, 32'hFFFF_FFFC);
        step(); step();
        #1;
        chk("tlb.wrap_pc", cache_req_pc, 32'h0);
        chk("tlb.wrap_out", out_pc, 32'hFFFF_FFFC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
